// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the AES inverse-cipher datapath.
package aes_pkg;

    typedef logic [0:127] state_t;
    typedef logic [7:0]   byte_t;
    typedef logic [0:31]  col_t;

    // Low byte of the reduction polynomial x^8+x^4+x^3+x+1.
    localparam byte_t AES_POLY = 8'h1B;

    // Multiply by x modulo the AES polynomial.
    function automatic byte_t xtime(input byte_t x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    // 09 = x8 ^ x
    function automatic byte_t gf_mul9(input byte_t x);
        byte_t x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x;
    endfunction

    // 0b = x8 ^ x2 ^ x
    function automatic byte_t gf_mulb(input byte_t x);
        byte_t x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ x;
    endfunction

    // 0d = x8 ^ x4 ^ x
    function automatic byte_t gf_muld(input byte_t x);
        byte_t x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x;
    endfunction

    // 0e = x8 ^ x4 ^ x2
    function automatic byte_t gf_mule(input byte_t x);
        byte_t x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/aes_inv_mix_columns_inv_mix_column.sv
// Combinational InvMixColumns of a single 4-byte column (row 0 in the top byte).
module inv_mix_column
    import aes_pkg::*;
(
    input  logic [0:31] col_in,
    output logic [0:31] col_out
);

    byte_t a0_s, a1_s, a2_s, a3_s;
    byte_t b0_s, b1_s, b2_s, b3_s;

    assign a0_s = col_in[0:7];
    assign a1_s = col_in[8:15];
    assign a2_s = col_in[16:23];
    assign a3_s = col_in[24:31];

    // Circulant matrix product [0e 0b 0d 09] rotated one step per row.
    always_comb begin
        b0_s = gf_mule(a0_s) ^ gf_mulb(a1_s) ^ gf_muld(a2_s) ^ gf_mul9(a3_s);
        b1_s = gf_mul9(a0_s) ^ gf_mule(a1_s) ^ gf_mulb(a2_s) ^ gf_muld(a3_s);
        b2_s = gf_muld(a0_s) ^ gf_mul9(a1_s) ^ gf_mule(a2_s) ^ gf_mulb(a3_s);
        b3_s = gf_mulb(a0_s) ^ gf_muld(a1_s) ^ gf_mul9(a2_s) ^ gf_mule(a3_s);
    end

    assign col_out = {b0_s, b1_s, b2_s, b3_s};

endmodule

// File: rtl/aes_inv_mix_columns.sv
// Registered AES InvMixColumns: four independent column transforms, one-cycle latency.
module aes_inv_mix_columns
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [0:127] message,
    output logic         out_valid,
    output logic [0:127] crypte
);

    state_t result_s;
    state_t crypte_r;
    logic   out_valid_r;

    // Columns never exchange data, so each gets its own transform instance.
    genvar c;
    generate
        for (c = 0; c < 4; c++) begin : g_col
            inv_mix_column u_col (
                .col_in  (message[32*c +: 32]),
                .col_out (result_s[32*c +: 32])
            );
        end
    endgenerate

    // Capture the result only on accepted inputs; reset wins over a concurrent input.
    always_ff @(posedge clk) begin
        if (rst) begin
            crypte_r    <= 128'h0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                crypte_r <= result_s;
            end else begin
                crypte_r <= crypte_r;
            end
        end
    end

    assign crypte    = crypte_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_aes_inv_mix_columns.sv
// Scoreboard bench for aes_inv_mix_columns: directed vectors plus random round-trips.
module tb_aes_inv_mix_columns;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [0:127] message = '0;
    logic         out_valid;
    logic [0:127] crypte;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_q[$];
    logic         exp_vld  = 1'b0;
    logic         rst_prev = 1'b0;
    logic [127:0] held     = '0;
    bit           mon_on   = 1'b0;

    aes_inv_mix_columns dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .message   (message),
        .out_valid (out_valid),
        .crypte    (crypte)
    );

    always #5 clk = ~clk;

    // Generic shift-and-add GF(2^8) multiply with explicit 0x11B reduction.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    // Apply a circulant matrix (first row in coef, byte 0 topmost) to every column.
    function automatic logic [127:0] mat(input logic [127:0] s, input logic [31:0] coef);
        logic [127:0] r;
        logic [7:0]   acc, a, k;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    a   = s[127 - 8*(4*c + j) -: 8];
                    k   = coef[31 - 8*((j - row + 4) % 4) -: 8];
                    acc = acc ^ gmul(a, k);
                end
                r[127 - 8*(4*c + row) -: 8] = acc;
            end
        return r;
    endfunction

    function automatic logic [127:0] inv_ref(input logic [127:0] s);
        return mat(s, 32'h0e0b0d09);
    endfunction

    function automatic logic [127:0] fwd_ref(input logic [127:0] s);
        return mat(s, 32'h02030101);
    endfunction

    // Reference view of what the DUT accepted at this edge.
    always @(posedge clk) begin
        exp_vld  = in_valid && !rst;
        rst_prev = rst;
    end

    // Monitor: compare handshake every cycle, pop the scoreboard on each output.
    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            if (out_valid !== exp_vld) begin
                errors++;
                $display("FAIL out_valid: got %b expected %b at %0t", out_valid, exp_vld, $time);
            end
            if (exp_vld) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty at %0t", $time);
                end else begin
                    held = exp_q.pop_front();
                end
            end else if (rst_prev) begin
                held = '0;
            end
            checks++;
            if (crypte !== held) begin
                errors++;
                $display("FAIL crypte: got %h expected %h at %0t", crypte, held, $time);
            end
        end
    end

    // Drive one cycle of stimulus; push the expected result when it will be accepted.
    task automatic drive(input logic v, input logic [127:0] msg, input logic r,
                         input logic [127:0] expv);
        @(posedge clk);
        #1;
        in_valid = v;
        message  = msg;
        rst      = r;
        if (v && !r) exp_q.push_back(expv);
    endtask

    localparam logic [127:0] V_FIPS_IN  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] V_FIPS_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] V_COL_IN   = 128'h8e4da1bc_01010101_c6c6c6c6_d5d5d7d6;
    localparam logic [127:0] V_COL_OUT  = 128'hdb135345_01010101_c6c6c6c6_d4d4d4d5;
    localparam logic [127:0] ONES       = {128{1'b1}};

    initial begin
        logic [127:0] s, m;
        logic         v;

        // Reset held for two cycles with a live all-ones input.
        in_valid = 1'b1;
        message  = ONES;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        drive(1'b1, ONES, 1'b1, '0);
        drive(1'b0, ONES, 1'b0, '0);
        drive(1'b0, '0, 1'b0, '0);

        // Known vectors and zero/hold behaviour.
        drive(1'b1, V_FIPS_IN, 1'b0, V_FIPS_OUT);
        drive(1'b1, V_COL_IN, 1'b0, V_COL_OUT);
        drive(1'b1, '0, 1'b0, '0);
        drive(1'b0, V_FIPS_IN, 1'b0, '0);
        drive(1'b0, V_COL_IN, 1'b0, '0);
        drive(1'b0, ONES, 1'b0, '0);
        drive(1'b1, V_FIPS_IN, 1'b0, V_FIPS_OUT);
        drive(1'b0, ONES, 1'b0, '0);

        // Streaming, then the same stream with reset on the second input.
        drive(1'b1, V_FIPS_IN, 1'b0, V_FIPS_OUT);
        drive(1'b1, V_COL_IN, 1'b0, V_COL_OUT);
        drive(1'b1, '0, 1'b0, '0);
        drive(1'b1, V_COL_IN, 1'b0, V_COL_OUT);
        drive(1'b1, V_FIPS_IN, 1'b1, '0);
        drive(1'b1, V_COL_IN, 1'b0, V_COL_OUT);
        drive(1'b0, '0, 1'b0, '0);

        // Random round-trips: forward MixColumns then this block must return the original.
        for (int i = 0; i < 1000; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            m = fwd_ref(s);
            v = ($urandom_range(7) != 0);
            if (v) begin
                checks++;
                if (inv_ref(m) !== s) begin
                    errors++;
                    $display("FAIL ref_roundtrip: got %h expected %h", inv_ref(m), s);
                end
            end
            drive(v, v ? m : {$urandom, $urandom, $urandom, $urandom}, 1'b0, s);
        end

        drive(1'b0, '0, 1'b0, '0);
        drive(1'b0, '0, 1'b0, '0);
        @(posedge clk);
        #1;
        mon_on = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_inv_mix_columns.md
Name: aes_inv_mix_columns

Overview:
- Registered AES-128 InvMixColumns transform, as specified in FIPS-197 §5.3.3, for the decryption datapath.
- Takes a 128-bit state and multiplies each 4-byte column by the fixed GF(2^8) matrix [0e 0b 0d 09; 09 0e 0b 0d; 0d 09 0e 0b; 0b 0d 09 0e].
- Sits between InvShiftRows/InvSubBytes and AddRoundKey in the inverse cipher round.
- Single clock, one-cycle latency, valid-qualified.

Parameters:
- none; state width is fixed at 128 bits (16 bytes, 4 columns).

Ports:
- clk       input   1        rising-edge clock
- rst       input   1        synchronous, active-high reset
- in_valid  input   1        message carries a state to transform this cycle
- message   input   [0:127]  input state; bit 0 is the MSB of byte 0
- out_valid output  1        crypte holds a freshly computed result
- crypte    output  [0:127]  transformed state; same byte layout as message

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Byte layout:
  - byte k = message[8k +: 8], k = 0..15.
  - State is column-major: column c = bytes 4c, 4c+1, 4c+2, 4c+3 (rows 0..3).
- Per column, inputs a0..a3, outputs b0..b3:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- GF(2^8) arithmetic:
  - Reduction polynomial x^8+x^4+x^3+x+1 (0x11B).
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
  - 09 = x8^x; 0b = x8^x2^x; 0d = x8^x4^x; 0e = x8^x4^x2, where x2 = xtime(x), x4 = xtime(x2), x8 = xtime(x4).
  - Addition is XOR; no carries, all values 8-bit.
- Columns are independent; no cross-column data flow.
- Latency: combinational transform of message, registered on the clk edge where in_valid=1. Results appear on crypte with out_valid=1 in the following cycle.
- Throughput: one state per cycle; back-to-back in_valid is accepted every cycle. No backpressure port.
- in_valid=0: crypte holds its last value; out_valid deasserts next cycle.
- Reset:
  - While rst=1 at a clk edge: crypte <= 0 and out_valid <= 0.
  - rst has priority over a simultaneous in_valid, so the input is dropped.
  - Reset mid-stream discards the in-flight result.
- After reset, crypte=0 and out_valid=0 until the first accepted input.
- No X propagation: message is sampled only when in_valid=1 and rst=0.

Decomposition:
- Package aes_pkg:
  - typedef state_t = logic [0:127]; typedef byte_t = logic [7:0]; typedef col_t = logic [0:31].
  - functions xtime, gf_mul9, gf_mulb, gf_muld, gf_mule.
  - constant AES_POLY = 8'h1B.
- Sub-module inv_mix_column: purely combinational, 32-bit column in and 32-bit column out. Instantiated 4× (generate loop).
- Top module holds only the input mux and the output/valid registers.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 and message=all-ones -> crypte=0 and out_valid=0 during reset and one cycle after release.
- FIPS-197 vector: in_valid=1, message=128'h046681e5_e0cb199a_48f8d37a_2806264c -> next cycle out_valid=1, crypte=128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5.
- Column identities: message=128'h8e4da1bc_01010101_c6c6c6c6_d5d5d7d6 -> crypte=128'hdb135345_01010101_c6c6c6c6_d4d4d4d5.
- Zero/hold: message=0 with in_valid=1 -> crypte=0. Then in_valid=0 for 3 cycles with message changing -> crypte unchanged, out_valid=0.
- Streaming: apply the vectors above on 3 consecutive cycles -> correct results on 3 consecutive cycles with out_valid continuously high. Assert rst on the 2nd input cycle -> that result is dropped and crypte=0.
- Round-trip: 1000 random states through a reference MixColumns, then this block -> output equals the original state; also check the per-column reference model byte-for-byte.
